// File: rtl/collector_pkg.sv
// Shared widths, transmitter state encoding and helpers for the collector UART ports.
package collector_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // A programmed period of zero behaves as a one-cycle bit.
  function automatic logic [BAUD_W-1:0] eff_period(input logic [BAUD_W-1:0] baud);
    return (baud == '0) ? BAUD_W'(1) : baud;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; full/empty/overflow are registered.
module tx_fifo
  import collector_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_ovf,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              push_ok;
  logic              pop_ok;

  // Push is gated by the registered full flag, so a same-cycle pop never frees a slot.
  always_comb begin
    push_ok  = i_push && !full_q;
    pop_ok   = i_pop && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = i_push && full_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_ovf   = ovf_q;
  assign o_count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1/8N2 serialiser with a per-frame latched bit period.
module uart_tx_buffered
  import collector_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_D,
  input  logic        i_write,
  input  logic [15:0] i_baud,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_busy,
  output logic        o_ovf,
  output logic        o_tx
);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BAUD_W-1:0] period_q, period_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic              pop_c;
  logic              load_c;
  logic              bit_end_c;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  tx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_write),
    .i_data  (i_D),
    .i_pop   (pop_c),
    .o_head  (fifo_head),
    .o_full  (o_full),
    .o_empty (fifo_empty),
    .o_ovf   (o_ovf),
    .o_count ()
  );

  // Next-state, shift register and line value; load_c starts a frame from IDLE or end of STOP.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    period_d   = period_q;
    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    load_c     = 1'b0;
    bit_end_c  = (baud_cnt_q == (period_q - BAUD_W'(1)));

    case (state_q)
      TX_IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        load_c     = !fifo_empty;
      end
      TX_START: begin
        if (bit_end_c) begin
          tx_d       = sh_q[0];
          bit_idx_d  = '0;
          baud_cnt_d = '0;
          state_d    = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end_c) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d       = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = TX_STOP;
          end else begin
            sh_d      = sh_q >> 1;
            tx_d      = sh_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end_c) begin
          baud_cnt_d = '0;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            if (fifo_empty) begin
              state_d = TX_IDLE;
            end else begin
              load_c = 1'b1;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        state_d    = TX_IDLE;
      end
    endcase

    if (load_c) begin
      sh_d       = fifo_head;
      period_d   = eff_period(i_baud);
      tx_d       = 1'b0;
      baud_cnt_d = '0;
      state_d    = TX_START;
    end

    pop_c  = load_c;
    busy_d = (state_d != TX_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= TX_IDLE;
      sh_q       <= '0;
      period_q   <= BAUD_W'(1);
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      period_q   <= period_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign o_empty = fifo_empty;
  assign o_busy  = busy_q;
  assign o_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: one-stop and two-stop instances checked against a frame-level model.
module tb_uart_tx_buffered;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_D = '0;
  logic        i_write = 1'b0;
  logic [15:0] i_baud = 16'd4;

  logic full1, empty1, busy1, ovf1, tx1;
  logic full2, empty2, busy2, ovf2, tx2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int ovf_cnt1 = 0, ovf_cnt2 = 0, busy_cnt1 = 0, busy_cnt2 = 0;

  always #5 i_clk = ~i_clk;

  uart_tx_buffered #(.DEPTH(DEPTH), .STOP_BITS(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_D(i_D), .i_write(i_write), .i_baud(i_baud),
    .o_full(full1), .o_empty(empty1), .o_busy(busy1), .o_ovf(ovf1), .o_tx(tx1)
  );

  uart_tx_buffered #(.DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_D(i_D), .i_write(i_write), .i_baud(i_baud),
    .o_full(full2), .o_empty(empty2), .o_busy(busy2), .o_ovf(ovf2), .o_tx(tx2)
  );

  // Frame-level model: a byte queue per instance and a position within the current frame.
  logic [7:0] m_mem [2][DEPTH];
  int         m_cnt [2];
  int         m_hd  [2];
  bit         m_act [2];
  logic [7:0] m_byte[2];
  int         m_per [2];
  int         m_len [2];
  int         m_pos [2];
  logic       m_tx [2], m_busy [2], m_full [2], m_empty [2], m_ovf [2];

  function automatic logic line_level(input logic [7:0] b, input int per, input int pos);
    int slot;
    slot = pos / per;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int u = 0; u < 2; u++) begin
        m_cnt[u] = 0; m_hd[u] = 0; m_act[u] = 1'b0; m_pos[u] = 0; m_len[u] = 0;
        m_per[u] = 1; m_byte[u] = '0;
        m_tx[u] = 1'b1; m_busy[u] = 1'b0; m_full[u] = 1'b0; m_empty[u] = 1'b1; m_ovf[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        int pre;
        pre = m_cnt[u];
        if (m_act[u] && (m_pos[u] + 1 < m_len[u])) begin
          m_pos[u]++;
        end else begin
          m_act[u] = 1'b0;
          if (pre > 0) begin
            m_byte[u] = m_mem[u][m_hd[u]];
            m_hd[u]   = (m_hd[u] + 1) % DEPTH;
            m_cnt[u]--;
            m_per[u]  = (i_baud == 16'd0) ? 1 : int'(i_baud);
            m_len[u]  = (9 + u + 1) * m_per[u];
            m_pos[u]  = 0;
            m_act[u]  = 1'b1;
          end
        end
        m_ovf[u] = i_write && (pre == DEPTH);
        if (i_write && (pre < DEPTH)) begin
          m_mem[u][(m_hd[u] + m_cnt[u]) % DEPTH] = i_D;
          m_cnt[u]++;
        end
        m_tx[u]    = m_act[u] ? line_level(m_byte[u], m_per[u], m_pos[u]) : 1'b1;
        m_busy[u]  = m_act[u];
        m_full[u]  = (m_cnt[u] == DEPTH);
        m_empty[u] = (m_cnt[u] == 0);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int u, input logic tx, input logic busy, input logic full,
                           input logic empty, input logic ovf);
    check($sformatf("tx%0d", u + 1),    64'(tx),    64'(m_tx[u]));
    check($sformatf("busy%0d", u + 1),  64'(busy),  64'(m_busy[u]));
    check($sformatf("full%0d", u + 1),  64'(full),  64'(m_full[u]));
    check($sformatf("empty%0d", u + 1), 64'(empty), 64'(m_empty[u]));
    check($sformatf("ovf%0d", u + 1),   64'(ovf),   64'(m_ovf[u]));
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check_dut(0, tx1, busy1, full1, empty1, ovf1);
      check_dut(1, tx2, busy2, full2, empty2, ovf2);
    end
    if (ovf1) ovf_cnt1++;
    if (ovf2) ovf_cnt2++;
    if (busy1) busy_cnt1++;
    if (busy2) busy_cnt2++;
  end

  task automatic push(input logic [7:0] d);
    i_D = d;
    i_write = 1'b1;
    @(negedge i_clk);
    i_write = 1'b0;
  endtask

  // Samples the selected line on the next n falling edges, first sample in the MSB position.
  task automatic capture(input int u, input int n, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      v = {v[62:0], (u == 0) ? tx1 : tx2};
      i_write = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(!busy1 && !busy2 && empty1 && empty2) && k < 4000) begin
      @(negedge i_clk);
      k++;
    end
    n_tests++;
    if (k >= 4000) begin
      n_fail++;
      $display("FAIL wait_idle: transmitters still busy after %0d cycles", k);
    end
    @(negedge i_clk);
  endtask

  initial begin
    logic [63:0] v;

    // Reset state
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_tx", 64'(tx1), 64'd1);
    check("rst_full", 64'(full1), 64'd0);
    check("rst_empty", 64'(empty1), 64'd1);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_ovf", 64'(ovf1), 64'd0);
    chk_en = 1'b1;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);

    // 0xA5 at period 4: start, 10100101 LSB first, stop
    i_baud = 16'd4;
    push(8'hA5);
    check("a5_latency", 64'(tx1), 64'd1);
    capture(0, 41, v);
    check("a5_frame", 64'(v[40:1]), 64'h0F0F00F0FF);
    check("a5_after", 64'(v[0]), 64'd1);
    wait_idle();

    // Period 0 and 1 give identical single-cycle bits
    i_baud = 16'd0;
    push(8'h0F);
    capture(0, 10, v);
    check("baud0_frame", 64'(v[9:0]), 64'(10'b0111100001));
    wait_idle();
    i_baud = 16'd1;
    push(8'h0F);
    capture(0, 10, v);
    check("baud1_frame", 64'(v[9:0]), 64'(10'b0111100001));
    wait_idle();

    // Six back-to-back pushes into a four-entry FIFO
    i_baud = 16'd2;
    ovf_cnt1 = 0;
    ovf_cnt2 = 0;
    for (int i = 0; i < 6; i++) begin
      i_D = 8'(8'h10 + i);
      i_write = 1'b1;
      @(negedge i_clk);
    end
    i_write = 1'b0;
    wait_idle();
    check("ovf_pulses1", 64'(ovf_cnt1), 64'd1);
    check("ovf_pulses2", 64'(ovf_cnt2), 64'd1);

    // Period change mid-frame only affects the following frame
    i_baud = 16'd4;
    busy_cnt1 = 0;
    busy_cnt2 = 0;
    i_D = 8'h3C;
    i_write = 1'b1;
    @(negedge i_clk);
    i_D = 8'hC3;
    @(negedge i_clk);
    i_write = 1'b0;
    repeat (20) @(negedge i_clk);
    i_baud = 16'd8;
    wait_idle();
    check("baud_change_busy1", 64'(busy_cnt1), 64'd120);
    check("baud_change_busy2", 64'(busy_cnt2), 64'd132);

    // Asynchronous reset in the middle of the data bits
    i_baud = 16'd4;
    push(8'hF0);
    push(8'h81);
    repeat (10) @(negedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1;
    check("mid_rst_tx1", 64'(tx1), 64'd1);
    check("mid_rst_busy1", 64'(busy1), 64'd0);
    check("mid_rst_empty1", 64'(empty1), 64'd1);
    check("mid_rst_tx2", 64'(tx2), 64'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    push(8'h55);
    capture(0, 40, v);
    check("post_rst_55", 64'(v[39:0]), 64'h0F0F0F0F0F);
    wait_idle();

    // Two stop bits, period 3: 27 low cycles, 6 high, then the next start bit
    i_baud = 16'd3;
    i_D = 8'h00;
    i_write = 1'b1;
    @(negedge i_clk);
    capture(1, 34, v);
    check("two_stop_frame", 64'(v[33:0]), 64'({27'b0, 6'b111111, 1'b0}));
    wait_idle();

    // Random traffic with occasional period changes
    for (int c = 0; c < 3000; c++) begin
      i_write = ($urandom_range(0, 3) == 0);
      i_D = 8'($urandom);
      if ($urandom_range(0, 199) == 0) i_baud = 16'($urandom_range(0, 6));
      @(negedge i_clk);
    end
    i_write = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
